// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - elastic MEM/WB pipeline stage with two-entry skid buffer, flush and stall counter
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int WB_W   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [DATA_W-1:0] ReadMem_i,
    input  logic [DATA_W-1:0] ALUresult_i,
    input  logic [ADDR_W-1:0] RDdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [WB_W-1:0]   WB_o,
    output logic [DATA_W-1:0] ReadMem_o,
    output logic [DATA_W-1:0] ALUresult_o,
    output logic [ADDR_W-1:0] RDdata_o,
    output logic              RegWrite_o,
    output logic [DATA_W-1:0] WriteData_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   in_ready_q;
    logic   in_fire, out_fire;
    logic   load_main, load_skid, skid_to_main;

    logic [WB_W-1:0]   main_wb_q,  skid_wb_q;
    logic [DATA_W-1:0] main_rm_q,  skid_rm_q;
    logic [DATA_W-1:0] main_alu_q, skid_alu_q;
    logic [ADDR_W-1:0] main_rd_q,  skid_rd_q;
    logic [CNT_W-1:0]  stall_q;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != S_EMPTY);
    assign in_fire     = in_valid_i & in_ready_q;
    assign out_fire    = out_valid_o & out_ready_i;

    // in_ready is decoded from the next state so it never depends combinationally on out_ready_i
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (in_fire) state_d = S_ONE;
                S_ONE: begin
                    if (in_fire && !out_fire)      state_d = S_FULL;
                    else if (!in_fire && out_fire) state_d = S_EMPTY;
                end
                S_FULL:  if (out_fire) state_d = S_ONE;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (!flush_i) begin
            case (state_q)
                S_EMPTY: load_main = in_fire;
                S_ONE: begin
                    load_main = in_fire & out_fire;
                    load_skid = in_fire & ~out_fire;
                end
                S_FULL:  skid_to_main = out_fire;
                default: ;
            endcase
        end
    end

    // Flush only kills the control field; payload bits are left as-is
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            main_wb_q  <= '0;
            main_rm_q  <= '0;
            main_alu_q <= '0;
            main_rd_q  <= '0;
            skid_wb_q  <= '0;
            skid_rm_q  <= '0;
            skid_alu_q <= '0;
            skid_rd_q  <= '0;
        end else if (flush_i) begin
            main_wb_q <= '0;
            skid_wb_q <= '0;
        end else begin
            if (load_main) begin
                main_wb_q  <= WB_i;
                main_rm_q  <= ReadMem_i;
                main_alu_q <= ALUresult_i;
                main_rd_q  <= RDdata_i;
            end else if (skid_to_main) begin
                main_wb_q  <= skid_wb_q;
                main_rm_q  <= skid_rm_q;
                main_alu_q <= skid_alu_q;
                main_rd_q  <= skid_rd_q;
            end
            if (load_skid) begin
                skid_wb_q  <= WB_i;
                skid_rm_q  <= ReadMem_i;
                skid_alu_q <= ALUresult_i;
                skid_rd_q  <= RDdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_q <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign WB_o        = main_wb_q;
    assign ReadMem_o   = main_rm_q;
    assign ALUresult_o = main_alu_q;
    assign RDdata_o    = main_rd_q;
    assign stall_cnt_o = stall_q;
    assign RegWrite_o  = out_valid_o & main_wb_q[0] & (main_rd_q != '0);
    assign WriteData_o = main_wb_q[1] ? main_rm_q : main_alu_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0]  wb_in, wb_out;
    logic [31:0] rm_in, alu_in, rm_out, alu_out, wd_out;
    logic [4:0]  rd_in, rd_out;
    logic        regwrite;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid, s_regwrite;
    logic [1:0]  s_wb;
    logic [31:0] s_rm, s_alu, s_wd;
    logic [4:0]  s_rd;
    logic [1:0]  s_stall;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .flush_i(flush), .WB_i(wb_in), .ReadMem_i(rm_in), .ALUresult_i(alu_in),
        .RDdata_i(rd_in), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .WB_o(wb_out), .ReadMem_o(rm_out), .ALUresult_o(alu_out), .RDdata_o(rd_out),
        .RegWrite_o(regwrite), .WriteData_o(wd_out), .stall_cnt_o(stall_cnt)
    );

    mem_wb_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .flush_i(flush), .WB_i(wb_in), .ReadMem_i(rm_in), .ALUresult_i(alu_in),
        .RDdata_i(rd_in), .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .WB_o(s_wb), .ReadMem_o(s_rm), .ALUresult_o(s_alu), .RDdata_o(s_rd),
        .RegWrite_o(s_regwrite), .WriteData_o(s_wd), .stall_cnt_o(s_stall)
    );

    typedef struct packed {
        logic [1:0]  wb;
        logic [31:0] rm;
        logic [31:0] alu;
        logic [4:0]  rd;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    pops   = 0;
    int    cyc    = 0;
    int    c0, p0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares the head beat whenever one is presented, pops on out-fire
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q[0];
                    chk("wb_o", 64'(wb_out), 64'(mon_e.wb));
                    chk("readmem_o", 64'(rm_out), 64'(mon_e.rm));
                    chk("aluresult_o", 64'(alu_out), 64'(mon_e.alu));
                    chk("rddata_o", 64'(rd_out), 64'(mon_e.rd));
                    chk("regwrite_o", 64'(regwrite), 64'(mon_e.wb[0] && (mon_e.rd != 5'd0)));
                    chk("writedata_o", 64'(wd_out), 64'(mon_e.wb[1] ? mon_e.rm : mon_e.alu));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [1:0] wb, input logic [31:0] rm, input logic [31:0] alu,
                        input logic [4:0] rd);
        bit fired = 1'b0;
        in_valid = 1'b1;
        wb_in    = wb;
        rm_in    = rm;
        alu_in   = alu;
        rd_in    = rd;
        for (int i = 0; i < 20 && !fired; i++) begin
            @(negedge clk);
            fired = (in_ready === 1'b1) && !flush;
            @(posedge clk);
            #1;
            if (fired) exp_q.push_back('{wb, rm, alu, rd});
        end
        in_valid = 1'b0;
        if (!fired) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb_in = '0; rm_in = '0; alu_in = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wb", 64'(wb_out), 64'd0);
        chk("rst_readmem", 64'(rm_out), 64'd0);
        chk("rst_alu", 64'(alu_out), 64'd0);
        chk("rst_rd", 64'(rd_out), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_regwrite", 64'(regwrite), 64'd0);
        chk("rst_writedata", 64'(wd_out), 64'd0);
        rst_n = 1'b1;

        // single beat through ALU path
        out_ready = 1'b1;
        send(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_regwrite", 64'(regwrite), 64'd1);
        chk("single_writedata", 64'(wd_out), 64'h1234);
        tick();
        chk("single_drain", 64'(out_valid), 64'd0);

        // MemtoReg path and r0 suppression
        send(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5);
        chk("memtoreg_writedata", 64'(wd_out), 64'hDEAD_BEEF);
        chk("memtoreg_regwrite", 64'(regwrite), 64'd1);
        send(2'b01, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0);
        chk("r0_valid", 64'(out_valid), 64'd1);
        chk("r0_regwrite", 64'(regwrite), 64'd0);
        tick();

        // back-pressure A, B, C from a fresh stall count
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        out_ready = 1'b0;
        send(2'b01, 32'hA0A0_0001, 32'h0000_000A, 5'd1);
        send(2'b11, 32'hB0B0_0002, 32'h0000_000B, 5'd2);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        chk("bp_stall_1", 64'(stall_cnt), 64'd1);
        in_valid = 1'b1; wb_in = 2'b01; rm_in = 32'hC0C0_0003; alu_in = 32'h0000_000C; rd_in = 5'd3;
        repeat (3) tick();
        chk("bp_c_held", 64'(in_ready), 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_stall_4", 64'(stall_cnt), 64'd4);
        chk("bp_stall_sat", 64'(s_stall), 64'd3);
        p0 = pops;
        out_ready = 1'b1;
        send(2'b01, 32'hC0C0_0003, 32'h0000_000C, 5'd3);
        tick();
        chk("bp_three_out", 64'(pops - p0), 64'd3);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("bp_stall_hold", 64'(stall_cnt), 64'd4);

        // flush in FULL with beat D offered
        out_ready = 1'b0;
        send(2'b01, 32'h1111_1111, 32'h0000_00E0, 5'd4);
        send(2'b01, 32'h2222_2222, 32'h0000_00F0, 5'd6);
        in_valid = 1'b1; wb_in = 2'b01; rm_in = 32'h3333_3333; alu_in = 32'h0000_00D0; rd_in = 5'd7;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_regwrite", 64'(regwrite), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_wb", 64'(wb_out), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_no_d", 64'(out_valid), 64'd0);
        send(2'b10, 32'hA5A5_A5A5, 32'h0000_0077, 5'd9);
        chk("post_flush_writedata", 64'(wd_out), 64'hA5A5_A5A5);
        chk("post_flush_regwrite", 64'(regwrite), 64'd0);
        tick();

        // throughput: 100 back-to-back beats
        c0 = cyc;
        p0 = pops;
        for (int i = 0; i < 100; i++) begin
            send(2'($urandom), $urandom, $urandom, 5'($urandom));
        end
        tick();
        chk("tput_cycles", 64'(cyc - c0), 64'd101);
        chk("tput_beats", 64'(pops - p0), 64'd100);
        chk("tput_queue_empty", 64'(exp_q.size()), 64'd0);

        // async reset pulsed between edges while FULL
        out_ready = 1'b0;
        send(2'b11, 32'h4444_4444, 32'h0000_0044, 5'd8);
        send(2'b01, 32'h5555_5555, 32'h0000_0055, 5'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_wb", 64'(wb_out), 64'd0);
        chk("arst_readmem", 64'(rm_out), 64'd0);
        chk("arst_alu", 64'(alu_out), 64'd0);
        chk("arst_rd", 64'(rd_out), 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        chk("arst_stall_sat", 64'(s_stall), 64'd0);
        chk("arst_writedata", 64'(wd_out), 64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(2'b01, 32'h6666_6666, 32'h0000_0ABC, 5'd12);
        chk("arst_first_regwrite", 64'(regwrite), 64'd1);
        chk("arst_first_writedata", 64'(wd_out), 64'h0ABC);
        tick();
        chk("arst_first_drained", 64'(exp_q.size()), 64'd0);

        // saturation of the narrow counter under a long stall
        out_ready = 1'b0;
        send(2'b01, 32'h7777_7777, 32'h0000_0777, 5'd13);
        repeat (5) tick();
        chk("sat_wide_count", 64'(stall_cnt), 64'd5);
        chk("sat_narrow_count", 64'(s_stall), 64'd3);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
